// File: rtl/sseg_scan_decoder.sv
// sseg_scan_decoder: display monitor for a multiplexed seven-segment bus.
// It watches the active-low anode, segment and decimal-point lines and
// rebuilds the per-digit hex value, decimal-point state and validity.
// Optional feature macro: SSEG_SCAN_DECODER_BIN_EN adds bin_value/bin_valid,
// which turn digit slots 2,1,0 back into a binary number after each frame.

module sseg_scan_decoder #(
    parameter int NUM_DIGITS    = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int STALE_LIMIT   = 65535
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   AN,
    input  logic [6:0]              sseg,
    input  logic                    DP,
    output logic [4*NUM_DIGITS-1:0] digit_value,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_dp,
    output logic                    frame_done,
    output logic                    glitch_err
`ifdef SSEG_SCAN_DECODER_BIN_EN
    ,
    output logic [9:0]              bin_value,
    output logic                    bin_valid
`endif
);

    localparam int IW = NUM_DIGITS + 8;
    localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam int SW = (STALE_LIMIT < 2) ? 1 : $clog2(STALE_LIMIT + 1);
    localparam int XW = (NUM_DIGITS < 2) ? 1 : $clog2(NUM_DIGITS);

    localparam logic [CW-1:0]         SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]         SETTLE_SAT  = CW'(SETTLE_CYCLES);
    localparam logic [SW-1:0]         STALE_MAX   = SW'(STALE_LIMIT);
    localparam logic [NUM_DIGITS-1:0] ONE_N       = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0] ZERO_N      = NUM_DIGITS'(0);

    // Active-low hex glyph to {recognised, nibble}; anything else is unknown.
    function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'b0000001: res = 5'b1_0000;
            7'b1001111: res = 5'b1_0001;
            7'b0010010: res = 5'b1_0010;
            7'b0000110: res = 5'b1_0011;
            7'b1001100: res = 5'b1_0100;
            7'b0100100: res = 5'b1_0101;
            7'b0100000: res = 5'b1_0110;
            7'b0001111: res = 5'b1_0111;
            7'b0000000: res = 5'b1_1000;
            7'b0000100: res = 5'b1_1001;
            7'b0001000: res = 5'b1_1010;
            7'b1100000: res = 5'b1_1011;
            7'b0110001: res = 5'b1_1100;
            7'b1000010: res = 5'b1_1101;
            7'b0110000: res = 5'b1_1110;
            7'b0111000: res = 5'b1_1111;
            default:    res = 5'b0_0000;
        endcase
        return res;
    endfunction

    // Position of the lowest active anode (only meaningful when one-hot).
    function automatic logic [XW-1:0] low_index(input logic [NUM_DIGITS-1:0] low);
        logic [XW-1:0] idx;
        idx = {XW{1'b0}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (low[i]) begin
                idx = XW'(i);
            end
        end
        return idx;
    endfunction

    // Saturating stale-counter increment.
    function automatic logic [SW-1:0] stale_inc(input logic [SW-1:0] cnt);
        return (cnt == STALE_MAX) ? cnt : (cnt + SW'(1));
    endfunction

    logic [IW-1:0]         in_s;
    logic [IW-1:0]         in_r;
    logic                  primed_r;
    logic [CW-1:0]         settle_cnt_r;
    logic [CW-1:0]         settle_nxt_s;
    logic [NUM_DIGITS-1:0] an_low_s;
    logic [6:0]            seg_s;
    logic                  dp_lit_s;
    logic [4:0]            glyph_s;
    logic                  blank_s;
    logic                  any_low_s;
    logic                  multi_low_s;
    logic [XW-1:0]         idx_s;
    logic                  capture_s;
    logic                  single_cap_s;
    logic                  glitch_nxt_s;
    logic                  wrap_s;
    logic                  first_r;
    logic [XW-1:0]         last_idx_r;
    logic [SW-1:0]         stale_r [NUM_DIGITS];

    assign in_s = {AN, sseg, DP};

    // Register the bus once and track how long it has stayed unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_r         <= {IW{1'b0}};
            primed_r     <= 1'b0;
            settle_cnt_r <= {CW{1'b0}};
        end else begin
            in_r         <= in_s;
            primed_r     <= 1'b1;
            settle_cnt_r <= settle_nxt_s;
        end
    end

    // Stability counter: restart on any change, saturate one past the capture
    // point so a long dwell is captured only once.
    always_comb begin
        settle_nxt_s = {CW{1'b0}};
        if (!primed_r || (in_s != in_r)) begin
            settle_nxt_s = {CW{1'b0}};
        end else if (settle_cnt_r == SETTLE_SAT) begin
            settle_nxt_s = settle_cnt_r;
        end else begin
            settle_nxt_s = settle_cnt_r + CW'(1);
        end
    end

    // Classify the settled bus: idle, single digit, or multi-anode glitch.
    always_comb begin
        an_low_s     = ~in_r[IW-1:8];
        seg_s        = in_r[7:1];
        dp_lit_s     = ~in_r[0];
        glyph_s      = glyph_decode(seg_s);
        blank_s      = (seg_s == 7'b1111111);
        any_low_s    = (an_low_s != ZERO_N);
        multi_low_s  = ((an_low_s & (an_low_s - ONE_N)) != ZERO_N);
        idx_s        = low_index(an_low_s);
        capture_s    = primed_r && (settle_cnt_r == SETTLE_LAST);
        single_cap_s = capture_s && any_low_s && !multi_low_s;
        glitch_nxt_s = capture_s && any_low_s &&
                       (multi_low_s || (!glyph_s[4] && !blank_s));
        wrap_s       = single_cap_s && !first_r && (idx_s <= last_idx_r);
    end

    // Slot registers and stale timers; a capture beats a same-cycle expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_value <= {(4*NUM_DIGITS){1'b0}};
            digit_valid <= {NUM_DIGITS{1'b0}};
            digit_dp    <= {NUM_DIGITS{1'b0}};
            for (int i = 0; i < NUM_DIGITS; i++) begin
                stale_r[i] <= {SW{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (single_cap_s && (idx_s == XW'(i))) begin
                    digit_value[4*i +: 4] <= glyph_s[4] ? glyph_s[3:0] : 4'h0;
                    digit_valid[i]        <= glyph_s[4];
                    digit_dp[i]           <= dp_lit_s;
                    stale_r[i]            <= glyph_s[4] ? {SW{1'b0}} : stale_inc(stale_r[i]);
                end else begin
                    stale_r[i] <= stale_inc(stale_r[i]);
                    if (stale_inc(stale_r[i]) == STALE_MAX) begin
                        digit_valid[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Frame-wrap detection and glitch reporting, both one-cycle pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
            glitch_err <= 1'b0;
            first_r    <= 1'b1;
            last_idx_r <= {XW{1'b0}};
        end else begin
            frame_done <= wrap_s;
            glitch_err <= glitch_nxt_s;
            if (single_cap_s) begin
                first_r    <= 1'b0;
                last_idx_r <= idx_s;
            end
        end
    end

`ifdef SSEG_SCAN_DECODER_BIN_EN
    // Three BCD digits back to binary: 100*d2 + 10*d1 + d0.
    function automatic logic [9:0] bcd3_to_bin(input logic [3:0] d2,
                                               input logic [3:0] d1,
                                               input logic [3:0] d0);
        return ({6'd0, d2} * 10'd100) + ({6'd0, d1} * 10'd10) + {6'd0, d0};
    endfunction

    logic bin_ok_s;

    // The low three slots form a usable number only if all are valid decimals.
    always_comb begin
        bin_ok_s = (digit_valid[2:0] == 3'b111) &&
                   (digit_value[3:0] <= 4'd9) &&
                   (digit_value[7:4] <= 4'd9) &&
                   (digit_value[11:8] <= 4'd9);
    end

    // Convert once per frame, the cycle after the wrap pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_value <= 10'd0;
            bin_valid <= 1'b0;
        end else if (frame_done) begin
            if (bin_ok_s) begin
                bin_value <= bcd3_to_bin(digit_value[11:8], digit_value[7:4], digit_value[3:0]);
                bin_valid <= 1'b1;
            end else begin
                bin_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: a transaction-level model pushes expected
// outputs (keyed by clock count) into a scoreboard when each dwell is driven;
// a negedge monitor pops and compares them against the DUT.

module tb_sseg_scan_decoder;

    localparam int N     = 8;
    localparam int S     = 4;
    localparam int STALE = 20;

    localparam int SEL_VAL = 0;
    localparam int SEL_VLD = 1;
    localparam int SEL_DP  = 2;
    localparam int SEL_FD  = 3;
    localparam int SEL_GE  = 4;
    localparam int SEL_BV  = 5;
    localparam int SEL_BOK = 6;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   AN;
    logic [6:0]     sseg;
    logic           DP;
    logic [4*N-1:0] digit_value;
    logic [N-1:0]   digit_valid;
    logic [N-1:0]   digit_dp;
    logic           frame_done;
    logic           glitch_err;
`ifdef SSEG_SCAN_DECODER_BIN_EN
    logic [9:0]     bin_value;
    logic           bin_valid;
`endif

    sseg_scan_decoder #(
        .NUM_DIGITS(N), .SETTLE_CYCLES(S), .STALE_LIMIT(STALE)
    ) dut (
        .clk(clk), .reset(reset), .AN(AN), .sseg(sseg), .DP(DP),
        .digit_value(digit_value), .digit_valid(digit_valid),
        .digit_dp(digit_dp), .frame_done(frame_done), .glitch_err(glitch_err)
`ifdef SSEG_SCAN_DECODER_BIN_EN
        , .bin_value(bin_value), .bin_valid(bin_valid)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Scoreboard: parallel queues kept sorted by check cycle.
    int          sb_cyc[$];
    int          sb_sel[$];
    logic [63:0] sb_exp[$];
    string       sb_tag[$];

    // Reference model state.
    int   m_val [N];
    bit   m_vld [N];
    bit   m_dp  [N];
    int   m_last;
    bit   m_first;
    int   m_bin;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input int n);
        case (n)
            0:  return 7'b0000001;  1:  return 7'b1001111;
            2:  return 7'b0010010;  3:  return 7'b0000110;
            4:  return 7'b1001100;  5:  return 7'b0100100;
            6:  return 7'b0100000;  7:  return 7'b0001111;
            8:  return 7'b0000000;  9:  return 7'b0000100;
            10: return 7'b0001000;  11: return 7'b1100000;
            12: return 7'b0110001;  13: return 7'b1000010;
            14: return 7'b0110000;  15: return 7'b0111000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int glyph_code(input logic [6:0] s);
        for (int n = 0; n < 16; n++) begin
            if (glyph(n) == s) return n;
        end
        return -1;
    endfunction

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            SEL_VAL: return 64'(digit_value);
            SEL_VLD: return 64'(digit_valid);
            SEL_DP:  return 64'(digit_dp);
            SEL_FD:  return 64'(frame_done);
            SEL_GE:  return 64'(glitch_err);
`ifdef SSEG_SCAN_DECODER_BIN_EN
            SEL_BV:  return 64'(bin_value);
            SEL_BOK: return 64'(bin_valid);
`endif
            default: return 64'hDEAD;
        endcase
    endfunction

    function automatic logic [63:0] vec_val();
        logic [63:0] v = 64'd0;
        for (int i = 0; i < N; i++) v[4*i +: 4] = 4'(m_val[i]);
        return v;
    endfunction

    function automatic logic [63:0] vec_vld();
        logic [63:0] v = 64'd0;
        for (int i = 0; i < N; i++) v[i] = m_vld[i];
        return v;
    endfunction

    function automatic logic [63:0] vec_dp();
        logic [63:0] v = 64'd0;
        for (int i = 0; i < N; i++) v[i] = m_dp[i];
        return v;
    endfunction

    task automatic expect_at(input int c, input int sel, input logic [63:0] e, input string tag);
        int pos = sb_cyc.size();
        for (int i = 0; i < sb_cyc.size(); i++) begin
            if (sb_cyc[i] > c) begin
                pos = i;
                break;
            end
        end
        sb_cyc.insert(pos, c);
        sb_sel.insert(pos, sel);
        sb_exp.insert(pos, e);
        sb_tag.insert(pos, tag);
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_val[i] = 0; m_vld[i] = 1'b0; m_dp[i] = 1'b0;
        end
        m_last = 0; m_first = 1'b1; m_bin = 0;
    endtask

    // Predict what a settled dwell does at capture cycle c.
    task automatic model_capture(input logic [N-1:0] an, input logic [6:0] seg,
                                 input logic dp, input int c);
        logic [N-1:0] low = ~an;
        int  cnt = 0;
        int  idx = 0;
        int  code;
        bit  wrap;
        for (int i = N - 1; i >= 0; i--) if (low[i]) begin cnt++; idx = i; end
        if (cnt == 0) begin
            expect_at(c, SEL_FD, 64'd0, "idle_fd");
            expect_at(c, SEL_GE, 64'd0, "idle_ge");
        end else if (cnt > 1) begin
            expect_at(c,     SEL_GE,  64'd1,     "multi_ge");
            expect_at(c + 1, SEL_GE,  64'd0,     "multi_ge_once");
            expect_at(c,     SEL_VAL, vec_val(), "multi_val");
            expect_at(c,     SEL_VLD, vec_vld(), "multi_vld");
        end else begin
            code = glyph_code(seg);
            wrap = !m_first && (idx <= m_last);
            m_first = 1'b0;
            m_last  = idx;
            m_val[idx] = (code >= 0) ? code : 0;
            m_vld[idx] = (code >= 0);
            m_dp[idx]  = ~dp;
            expect_at(c,     SEL_FD,  64'(wrap),  "fd");
            expect_at(c + 1, SEL_FD,  64'd0,      "fd_once");
            expect_at(c,     SEL_GE,  64'((code < 0) && (seg != 7'b1111111)), "ge");
            expect_at(c,     SEL_VAL, vec_val(),  "val");
            expect_at(c,     SEL_VLD, vec_vld(),  "vld");
            expect_at(c,     SEL_DP,  vec_dp(),   "dp");
`ifdef SSEG_SCAN_DECODER_BIN_EN
            if (wrap) begin
                if (m_vld[0] && m_vld[1] && m_vld[2] && m_val[0] <= 9 && m_val[1] <= 9 && m_val[2] <= 9) begin
                    m_bin = 100 * m_val[2] + 10 * m_val[1] + m_val[0];
                    expect_at(c + 1, SEL_BOK, 64'd1, "bin_ok");
                end else begin
                    expect_at(c + 1, SEL_BOK, 64'd0, "bin_ok");
                end
                expect_at(c + 1, SEL_BV, 64'(m_bin), "bin_val");
            end
`endif
        end
    endtask

    // Hold one bus pattern for 'hold' cycles, starting just after a negedge.
    task automatic dwell(input logic [N-1:0] an, input logic [6:0] seg,
                         input logic dp, input int hold);
        int base = cyc;
        AN = an; sseg = seg; DP = dp;
        if (hold >= S) model_capture(an, seg, dp, base + S + 1);
        repeat (hold) @(negedge clk);
    endtask

    task automatic do_reset(input bit idle_pins);
        int base = cyc;
        if (idle_pins) begin
            AN = '1; sseg = 7'b1111111; DP = 1'b1;
        end
        reset = 1'b1;
        expect_at(base + 1, SEL_VAL, 64'd0, "rst_val");
        expect_at(base + 1, SEL_VLD, 64'd0, "rst_vld");
        expect_at(base + 1, SEL_DP,  64'd0, "rst_dp");
        expect_at(base + 1, SEL_FD,  64'd0, "rst_fd");
        expect_at(base + 1, SEL_GE,  64'd0, "rst_ge");
`ifdef SSEG_SCAN_DECODER_BIN_EN
        expect_at(base + 1, SEL_BV,  64'd0, "rst_bv");
        expect_at(base + 1, SEL_BOK, 64'd0, "rst_bok");
`endif
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    // Monitor: compare every scoreboard entry that is due this cycle.
    always @(negedge clk) begin
        while (sb_cyc.size() > 0 && sb_cyc[0] <= cyc) begin
            check_val(sb_tag[0], observe(sb_sel[0]), sb_exp[0]);
            void'(sb_cyc.pop_front());
            void'(sb_sel.pop_front());
            void'(sb_exp.pop_front());
            void'(sb_tag.pop_front());
        end
    end

    initial begin
        int b;
        int c;
        reset = 1'b1; AN = '1; sseg = 7'b1111111; DP = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);

        // Single digit: slot0 = 3, checked one edge early too.
        do_reset(1'b1);
        expect_at(cyc + S, SEL_VLD, 64'd0, "early_vld");
        dwell(8'hFE, glyph(3), 1'b1, 6);

        // Scan 5,2,1 then back to slot 0: one frame_done at the wrap.
        do_reset(1'b1);
        dwell(8'hFE, glyph(5), 1'b1, 5);
        dwell(8'hFD, glyph(2), 1'b1, 5);
        dwell(8'hFB, glyph(1), 1'b1, 5);
        dwell(8'hFE, glyph(5), 1'b1, 5);
        dwell(8'hFF, 7'b1111111, 1'b1, 6);

        // Two anodes low: one glitch pulse, slots untouched.
        do_reset(1'b1);
        dwell(8'hFE, glyph(8), 1'b1, 5);
        dwell(8'hFC, glyph(8), 1'b1, 10);

        // Unknown glyph in slot 3 (also a wrap), then a blank with DP lit.
        do_reset(1'b1);
        dwell(8'hF7, glyph(14), 1'b1, 5);
        dwell(8'hF7, 7'b1010101, 1'b1, 5);
        dwell(8'hEF, 7'b1111111, 1'b0, 5);
        dwell(8'hFF, 7'b1111111, 1'b1, 5);

        // Stale expiry of slot 1 while the bus is idle.
        do_reset(1'b1);
        b = cyc;
        dwell(8'hFD, glyph(10), 1'b0, 5);
        c = b + S + 1;
        expect_at(c + STALE - 1, SEL_VLD, 64'h02, "stale_pre");
        expect_at(c + STALE,     SEL_VLD, 64'h00, "stale_vld");
        expect_at(c + STALE,     SEL_VAL, 64'h000000A0, "stale_val");
        expect_at(c + STALE,     SEL_DP,  64'h02, "stale_dp");
        dwell(8'hFF, 7'b1111111, 1'b1, 25);

        // Fast toggling never settles; then reset in the middle of a dwell.
        do_reset(1'b1);
        dwell(8'hFE, glyph(7), 1'b1, 5);
        for (int k = 0; k < 8; k++) begin
            b = cyc;
            expect_at(b + 1, SEL_FD,  64'd0,  "tog_fd");
            expect_at(b + 2, SEL_VLD, 64'h01, "tog_vld");
            expect_at(b + 2, SEL_VAL, 64'h7,  "tog_val");
            dwell((k % 2 == 0) ? 8'hFD : 8'hFB, (k % 2 == 0) ? glyph(3) : glyph(4), 1'b1, 2);
        end
        AN = 8'hFE; sseg = glyph(3); DP = 1'b1;
        repeat (2) @(negedge clk);
        do_reset(1'b0);
        b = cyc;
        expect_at(b + S, SEL_VLD, 64'd0, "fresh_wait");
        model_capture(8'hFE, glyph(3), 1'b1, b + S + 1);
        repeat (6) @(negedge clk);

        // Let outstanding expectations drain, bounded.
        for (int k = 0; k < 50 && sb_cyc.size() > 0; k++) @(negedge clk);
        if (sb_cyc.size() > 0) check_val("sb_drain", 64'(sb_cyc.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
